// File: rtl/mod_ex_ctrl.sv
// Execute-stage sequencer: ALU pass-through, iterative RV32M mul/div, result register.
// Define EX_FAST_MUL_EN to complete MUL/MULH/MULHSU/MULHU in one cycle.
module mod_ex_ctrl #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] immediate_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] alu_target_i,
    input  logic            alu_b_cond_met_i,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_result_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [5:0] CNT_LAST  = 6'(MD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MD_BUSY, MD_DONE} state_t;

    state_t state, state_nxt;

    logic              accept, is_md, is_div, div0, ovf, iter;
    logic              sa, sb, neg_a, neg_b, taken;
    logic [XLEN-1:0]   mag_a, mag_b, fast_md, fast_res, md_res;
    logic [XLEN-1:0]   md_q, md_r;
    logic [2*XLEN-1:0] acc, acc_init, prod;
    logic [XLEN-1:0]   md_opnd;
    logic [2:0]        md_f3;
    logic              md_neg, md_rneg;
    logic [4:0]        md_rd, rd_eff;
    logic [5:0]        cnt;
    logic              unused;

    assign unused = ^{pc_i, immediate_i};

    // One iteration: shift-add for multiply, restoring subtract for divide.
    // acc holds {high product | remainder, low product | quotient}.
    function automatic logic [2*XLEN-1:0] md_step(
        input logic [2*XLEN-1:0] a,
        input logic [XLEN-1:0]   d,
        input logic              div
    );
        logic [XLEN:0] t, s;
        t = '0;
        s = '0;
        if (div) begin
            t = a[2*XLEN-1:XLEN-1];
            s = t - {1'b0, d};
            if (!s[XLEN]) md_step = {s[XLEN-1:0], a[XLEN-2:0], 1'b1};
            else          md_step = {t[XLEN-1:0], a[XLEN-2:0], 1'b0};
        end else begin
            s = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, d} : '0);
            md_step = {s, a[XLEN-1:1]};
        end
    endfunction

    assign id_ready_o = (state == IDLE) && !flush_i
                        && (!ex_valid_o || ex_ready_i);
    assign accept = id_valid_i && id_ready_o;
    assign busy_o = (state != IDLE);

    assign is_md  = (opcode_i == OP_OP) && (funct7_i == 7'b0000001);
    assign is_div = funct3_i[2];
    assign div0   = is_div && (rs2_data_i == '0);
    assign ovf    = is_div && !funct3_i[0]
                    && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2_data_i == '1);

`ifdef EX_FAST_MUL_EN
    assign iter = is_md && is_div && !div0 && !ovf;
`else
    assign iter = is_md && !div0 && !ovf;
`endif

    assign sa    = is_div ? ~funct3_i[0] : (funct3_i != 3'b011);
    assign sb    = is_div ? ~funct3_i[0] : ~funct3_i[1];
    assign neg_a = sa && rs1_data_i[XLEN-1];
    assign neg_b = sb && rs2_data_i[XLEN-1];
    assign mag_a = neg_a ? -rs1_data_i : rs1_data_i;
    assign mag_b = neg_b ? -rs2_data_i : rs2_data_i;

    assign acc_init = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod;
    assign fprod = {{XLEN{neg_a}}, rs1_data_i}
                 * {{XLEN{neg_b}}, rs2_data_i};
`endif

    always_comb begin
        fast_md = '0;
        if (div0)     fast_md = funct3_i[1] ? rs1_data_i : '1;
        else if (ovf) fast_md = funct3_i[1] ? '0 : rs1_data_i;
`ifdef EX_FAST_MUL_EN
        else if (!is_div)
            fast_md = (funct3_i == 3'b000) ? fprod[XLEN-1:0]
                                           : fprod[2*XLEN-1:XLEN];
`endif
    end

    assign fast_res = is_md ? fast_md : alu_result_i;
    assign rd_eff   = (opcode_i == OP_BRANCH || opcode_i == OP_STORE)
                      ? 5'd0 : rd_addr_i;
    assign taken    = alu_b_cond_met_i && (opcode_i == OP_BRANCH
                      || opcode_i == OP_JAL || opcode_i == OP_JALR);

    always_comb begin
        prod   = md_neg ? -acc : acc;
        md_q   = md_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        md_r   = md_rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        md_res = prod[2*XLEN-1:XLEN];
        if (md_f3[2])             md_res = md_f3[1] ? md_r : md_q;
        else if (md_f3 == 3'b000) md_res = prod[XLEN-1:0];
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && iter) state_nxt = MD_BUSY;
            MD_BUSY: if (cnt == CNT_LAST) state_nxt = MD_DONE;
            MD_DONE: if (!ex_valid_o || ex_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_valid_o       <= 1'b0;
            ex_result_o      <= '0;
            ex_rd_addr_o     <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            acc              <= '0;
            md_opnd          <= '0;
            md_f3            <= '0;
            md_neg           <= 1'b0;
            md_rneg          <= 1'b0;
            md_rd            <= '0;
            cnt              <= '0;
        end else begin
            redirect_valid_o <= 1'b0;
            if (flush_i) begin
                ex_valid_o <= 1'b0;
            end else if (accept && !iter) begin
                ex_valid_o       <= 1'b1;
                ex_result_o      <= fast_res;
                ex_rd_addr_o     <= rd_eff;
                redirect_valid_o <= taken;
                if (taken) redirect_pc_o <= alu_target_i;
            end else if (state == MD_DONE
                         && (!ex_valid_o || ex_ready_i)) begin
                ex_valid_o   <= 1'b1;
                ex_result_o  <= md_res;
                ex_rd_addr_o <= md_rd;
            end else if (ex_ready_i) begin
                ex_valid_o <= 1'b0;
            end
            // The first iteration runs in the accept cycle.
            if (accept && iter) begin
                acc     <= md_step(acc_init, is_div ? mag_b : mag_a, is_div);
                md_opnd <= is_div ? mag_b : mag_a;
                md_f3   <= funct3_i;
                md_neg  <= neg_a ^ neg_b;
                md_rneg <= neg_a;
                md_rd   <= rd_addr_i;
                cnt     <= 6'd1;
            end else if (state == MD_BUSY) begin
                acc <= md_step(acc, md_opnd, md_f3[2]);
                cnt <= cnt + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_mod_ex_ctrl.sv
// Scoreboard bench for mod_ex_ctrl: directed latency cases plus random traffic
// against an arithmetic reference model.
module tb_mod_ex_ctrl;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] BR  = 7'b1100011, LD = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011, IMM = 7'b0010011;
    localparam logic [6:0] OP  = 7'b0110011;
`ifdef EX_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, id_valid_i, id_ready_o;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, immediate_i;
    logic [6:0]  opcode_i, funct7_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_addr_i, ex_rd_addr_o;
    logic [31:0] alu_result_i, alu_target_i, ex_result_o, redirect_pc_o;
    logic        alu_b_cond_met_i, ex_valid_o, ex_ready_i;
    logic        redirect_valid_o, busy_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic rand_bp = 1'b0;

    always #5 clk_i = ~clk_i;

    mod_ex_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .immediate_i(immediate_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_addr_i(rd_addr_i),
        .alu_result_i(alu_result_i), .alu_target_i(alu_target_i),
        .alu_b_cond_met_i(alu_b_cond_met_i), .ex_valid_o(ex_valid_o),
        .ex_ready_i(ex_ready_i), .ex_result_o(ex_result_o),
        .ex_rd_addr_o(ex_rd_addr_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint p;
        int ia, ib;
        logic ov;
        ia = $signed(a);
        ib = $signed(b);
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p  = 0;
        case (f3)
            3'd0: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
            3'd1: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
            3'd2: begin p = longint'(ia) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ov ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Called at post-posedge; returns right after the accepting edge (+1).
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        exp_t e;
        logic rdy;
        int   n;
        logic ctl;
        opcode_i = opc; funct3_i = f3; funct7_i = f7; rd_addr_i = rd;
        pc_i = pc; rs1_data_i = a; rs2_data_i = b; immediate_i = imm;
        case (opc)
            LUI:       alu_result_i = imm;
            AUIPC:     alu_result_i = pc + imm;
            JAL, JALR: alu_result_i = pc + 32'd4;
            OP:        alu_result_i = a + b;
            default:   alu_result_i = a + imm;
        endcase
        alu_target_i = (opc == JALR) ? ((a + imm) & ~32'd1) : pc + imm;
        ctl = (opc == BR) || (opc == JAL) || (opc == JALR);
        if (opc == BR)     alu_b_cond_met_i = (a == b);
        else if (ctl)      alu_b_cond_met_i = 1'b1;
        else               alu_b_cond_met_i = 1'($urandom_range(0, 1));
        e.res   = (opc == OP && f7 == 7'b0000001) ? ref_md(f3, a, b)
                                                  : alu_result_i;
        e.rd    = (opc == BR || opc == ST) ? 5'd0 : rd;
        e.redir = ctl && alu_b_cond_met_i;
        e.rpc   = alu_target_i;
        id_valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_i);
            rdy = id_ready_o;
            @(posedge clk_i);
            if (rdy) break;
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (rdy) sb.push_back(e);
        #1;
        id_valid_i = 1'b0;
        rs1_data_i = $urandom; rs2_data_i = $urandom;
        funct3_i = 3'($urandom); rd_addr_i = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        forever begin
            @(negedge clk_i);
            if (ex_valid_o) break;
            lat++;
            if (lat > 100) break;
        end
    endtask

    task automatic run(input string name, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] req,
                       input int req_lat);
        int lat;
        issue(opc, f3, f7, 5'd5, 32'h200, a, b, imm);
        wait_valid(lat);
        chk({name, "_latency"}, lat, req_lat);
        chk(name, ex_result_o, req);
        @(posedge clk_i); #1;
    endtask

    // Monitor: compares every valid cycle, pops on transfer.
    logic fresh = 1'b1;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ex_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    chk("result", ex_result_o, sb[0].res);
                    chk("rd_addr", ex_rd_addr_o, sb[0].rd);
                    if (fresh) begin
                        chk("redirect_valid", redirect_valid_o, sb[0].redir);
                        if (sb[0].redir)
                            chk("redirect_pc", redirect_pc_o, sb[0].rpc);
                    end else begin
                        chk("redirect_repeat", redirect_valid_o, 0);
                    end
                    if (ex_ready_i) void'(sb.pop_front());
                end
                fresh = ex_ready_i;
            end else begin
                fresh = 1'b1;
                if (redirect_valid_o) chk("stray_redirect", 1, 0);
            end
        end
    end

    always @(posedge clk_i) begin
        if (rand_bp) begin
            #1 ex_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int cnt;
        rst_ni = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
        pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; immediate_i = '0;
        opcode_i = '0; funct3_i = '0; funct7_i = '0; rd_addr_i = '0;
        alu_result_i = '0; alu_target_i = '0; alu_b_cond_met_i = 1'b0;

        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        chk("rst_ex_valid", ex_valid_o, 0);
        chk("rst_result", ex_result_o, 0);
        chk("rst_rd", ex_rd_addr_o, 0);
        chk("rst_redirect", redirect_valid_o, 0);
        chk("rst_redirect_pc", redirect_pc_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_id_ready", id_ready_o, 1);
        @(posedge clk_i); #1;

        run("addi", IMM, 3'd0, 7'd0, 32'd10, 32'd0, 32'hFFFF_FFFD, 32'd7, 1);
        run("divu", OP, 3'd5, 7'd1, 32'd100, 32'd7, 0, 32'd14, 33);
        run("rem", OP, 3'd6, 7'd1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 33);
        run("div_ovf", OP, 3'd4, 7'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0,
            32'h8000_0000, 1);
        run("divu_zero", OP, 3'd5, 7'd1, 32'd1234, 32'd0, 0, 32'hFFFF_FFFF, 1);
        run("rem_zero", OP, 3'd6, 7'd1, 32'hFFFF_FF00, 32'd0, 0, 32'hFFFF_FF00, 1);
        run("mulhu", OP, 3'd3, 7'd1, 32'hFFFF_FFFF, 32'd2, 0, 32'd1, MUL_LAT);
        run("mulh", OP, 3'd1, 7'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd0, MUL_LAT);
        run("mul", OP, 3'd0, 7'd1, 32'hFFFF_FFFD, 32'd7, 0, 32'hFFFF_FFEB, MUL_LAT);

        ex_ready_i = 1'b0;
        issue(BR, 3'd0, 7'd0, 5'd9, 32'h100, 32'd5, 32'd5, 32'h20);
        @(negedge clk_i);
        chk("beq_redirect", redirect_valid_o, 1);
        chk("beq_target", redirect_pc_o, 32'h120);
        chk("beq_rd", ex_rd_addr_o, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("beq_pulse_once", redirect_valid_o, 0);
            chk("beq_held_valid", ex_valid_o, 1);
            chk("beq_id_ready_held", id_ready_o, 0);
        end
        @(posedge clk_i); #1 ex_ready_i = 1'b1;
        @(posedge clk_i); #1;

        issue(OP, 3'd4, 7'd1, 5'd3, 32'h0, 32'd1000, 32'd3, 32'd0);
        repeat (9) @(posedge clk_i);
        #1 flush_i = 1'b1; id_valid_i = 1'b1;
        @(negedge clk_i);
        chk("flush_busy_before", busy_o, 1);
        chk("flush_blocks_ready", id_ready_o, 0);
        @(posedge clk_i);
        sb.delete();
        #1 flush_i = 1'b0; id_valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_busy_after", busy_o, 0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (ex_valid_o) cnt++;
        end
        chk("flush_no_result", cnt, 0);
        @(posedge clk_i); #1;
        run("addi_after_flush", IMM, 3'd0, 7'd0, 32'd10, 32'd0,
            32'hFFFF_FFFD, 32'd7, 1);

        rand_bp = 1'b1;
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a, b;
            int r;
            a = $urandom;
            b = $urandom;
            r = $urandom_range(0, 15);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) begin a = 32'($urandom_range(0, 50)); b = a; end
            if (r == 3) b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 0) begin
                issue(OP, 3'($urandom), 7'd1, 5'($urandom), $urandom, a, b, 0);
            end else begin
                logic [6:0] ops[9];
                ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OP};
                issue(ops[$urandom_range(0, 8)], 3'($urandom), 7'd0,
                      5'($urandom), $urandom, a, b, $urandom);
            end
            if ($urandom_range(0, 39) == 0) begin
                flush_i = 1'b1;
                @(posedge clk_i);
                sb.delete();
                #1 flush_i = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
            #0;
        end
        rand_bp = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1 ex_ready_i = 1'b1;
        cnt = 0;
        while (sb.size() != 0 && cnt < 200) begin
            @(posedge clk_i);
            cnt++;
        end
        chk("drain_pending", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
